// File: rtl/demux_bs_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer (channel indices, select decode).
package demux_bs_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CH_IDX_W = 2;

  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;
  localparam int unsigned CH_D = 3;

  // S0 is the MSB of the channel index, S1 the LSB.
  function automatic logic [CH_IDX_W-1:0] sel_idx(input logic s0, input logic s1);
    return {s0, s1};
  endfunction

endpackage

// File: rtl/demux_bs_slot.sv
// One-entry register slice for a single demux channel; a load in the same edge as a
// consume refills the slot so a channel sustains one word per cycle.
module demux_bs_slot
  import demux_bs_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         out_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_bs_reg.sv
// Registered 1-to-4 demux with per-channel valid/ready slices.
// Define DEMUX_BS_ROUND_ROBIN_EN to take the channel from an internal A,B,C,D pointer instead of S0/S1.
module demux_bs_reg
  import demux_bs_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [W-1:0] Din,
  input  logic         InValid,
  output logic         InReady,
  input  logic         S0,
  input  logic         S1,
  output logic [W-1:0] FA,
  output logic [W-1:0] FB,
  output logic [W-1:0] FC,
  output logic [W-1:0] FD,
  output logic [3:0]   OutValid,
  input  logic [3:0]   OutReady,
  output logic         Busy
);

  logic [CH_IDX_W-1:0] sel_c;
  logic                in_ready_c;
  logic                accept_c;
  logic [W-1:0]        data_c [NUM_CH];

`ifdef DEMUX_BS_ROUND_ROBIN_EN
  logic [CH_IDX_W-1:0] ptr_q, ptr_d;

  // Pointer only advances on an accepted word, so a stalled channel holds the order.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_c) begin
      ptr_d = ptr_q + CH_IDX_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign sel_c = ptr_q;
`else
  assign sel_c = sel_idx(S0, S1);
`endif

  assign in_ready_c = !Rst && (!OutValid[sel_c] || OutReady[sel_c]);
  assign accept_c   = InValid && in_ready_c;
  assign InReady    = in_ready_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_bs_slot #(.W(W)) u_slot (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .load_i      (accept_c && (sel_c == CH_IDX_W'(i))),
      .load_data_i (Din),
      .out_ready_i (OutReady[i]),
      .valid_o     (OutValid[i]),
      .data_o      (data_c[i])
    );
  end

  assign FA   = data_c[CH_A];
  assign FB   = data_c[CH_B];
  assign FC   = data_c[CH_C];
  assign FD   = data_c[CH_D];
  assign Busy = |OutValid;

endmodule
